spi_bus_ctrl: RTL and testbench

Transaction sequencer between the SPI frame decoder and the internal memory-mapped register/crypto bus. It consumes the decoder's frame pulses and fields (address, status, write data) and turns each SPI frame into single or burst bus reads/writes. It runs the bus req/ack handshake with a timeout, and presents read data to the decoder before the MISO phase starts. It reports sticky error conditions.

---
 rtl/spi_bus_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_spi_bus_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_ctrl.sv
// spi_bus_ctrl
// Turns decoded SPI frames into single or burst accesses on the internal
// memory-mapped bus. It runs the req/ack handshake with a timeout and holds
// read data for the decoder until the decoder has copied it. It also keeps
// sticky error flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no frame in progress; waiting for status_ready
// RD_REQ   | bus read: raise bus_req, then wait for ack or timeout
// RD_HOLD  | read data on rdata; waiting for the decoder's rdata_read
// WR_WAIT  | waiting for the decoder's data_ready (write payload)
// WR_REQ   | bus write: raise bus_req, then wait for ack or timeout
// DRAIN    | frame ended with a request outstanding; finish it, then IDLE
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cs_n_o              decoder chip select (1 = frame inactive)
//   status_ready        pulse: addr/status valid
//   data_ready          pulse: wdata valid
//   rdata_read          pulse: decoder has consumed rdata
//   addr, status, wdata decoder frame fields
//   rdata               read data to the decoder
//   bus_req/we/addr/wdata, bus_ack, bus_rdata   bus handshake
//   busy                controller not idle
//   err_timeout         sticky: a bus access timed out
//   err_proto           sticky: a frame pulse arrived in an illegal state
module spi_bus_ctrl #(
  parameter int                ADDR_W    = 20,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_STEP = 1,
  parameter int                TIMEOUT   = 64,
  parameter logic [DATA_W-1:0] ERR_DATA  = 16'hDEAD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n_o,
  input  logic              status_ready,
  input  logic              data_ready,
  input  logic              rdata_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        status,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_proto
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_HOLD = 3'd2,
    WR_WAIT = 3'd3,
    WR_REQ  = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  state_t            state_q,       state_d;
  logic [ADDR_W-1:0] addr_q,        addr_d;
  logic              burst_q,       burst_d;
  logic [DATA_W-1:0] rdata_q,       rdata_d;
  logic              bus_req_q,     bus_req_d;
  logic              bus_we_q,      bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q,    bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q,   bus_wdata_d;
  logic [CNT_W-1:0]  cnt_q,         cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_proto_q,   err_proto_d;

  logic req_done;
  logic req_to;
  logic req_finish;

  // Write/burst decode uses status[2:1]; the reserved bits are ignored.
  logic unused_status;
  assign unused_status = status[3] ^ status[0];

  // An ack in the last timeout cycle still counts as a good completion.
  assign req_done   = bus_req_q & bus_ack;
  assign req_to     = bus_req_q & ~bus_ack & (cnt_q == CNT_LAST);
  assign req_finish = req_done | req_to;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    burst_d       = burst_q;
    rdata_d       = rdata_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;
    err_proto_d   = err_proto_q;

    if (bus_req_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (status_ready) begin
          addr_d        = addr;
          burst_d       = status[1];
          err_timeout_d = 1'b0;
          err_proto_d   = 1'b0;
          state_d       = status[2] ? WR_WAIT : RD_REQ;
        end
      end

      RD_REQ: begin
        if (!bus_req_q) begin
          if (cs_n_o) begin
            state_d = IDLE;
          end else begin
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b0;
            bus_addr_d = addr_q;
            cnt_d      = '0;
          end
        end else if (req_finish) begin
          bus_req_d = 1'b0;
          rdata_d   = req_done ? bus_rdata : ERR_DATA;
          if (req_to) begin
            err_timeout_d = 1'b1;
          end
          state_d = cs_n_o ? IDLE : RD_HOLD;
        end else if (cs_n_o) begin
          state_d = DRAIN;
        end
      end

      RD_HOLD: begin
        if (cs_n_o) begin
          state_d = IDLE;
        end else if (rdata_read) begin
          if (burst_q) begin
            // Prefetch the next beat while the decoder shifts this one out.
            addr_d  = addr_q + ADDR_W'(ADDR_STEP);
            state_d = RD_REQ;
          end else begin
            state_d = IDLE;
          end
        end
      end

      WR_WAIT: begin
        if (cs_n_o) begin
          state_d = IDLE;
        end else if (data_ready) begin
          bus_wdata_d = wdata;
          state_d     = WR_REQ;
        end
      end

      WR_REQ: begin
        if (!bus_req_q) begin
          if (cs_n_o) begin
            state_d = IDLE;
          end else begin
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b1;
            bus_addr_d = addr_q;
            cnt_d      = '0;
          end
        end else if (req_finish) begin
          bus_req_d = 1'b0;
          if (req_to) begin
            err_timeout_d = 1'b1;
          end
          if (cs_n_o || !burst_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(ADDR_STEP);
            state_d = WR_WAIT;
          end
        end else if (cs_n_o) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // The frame is gone, so a late read result is not forwarded to rdata.
        if (req_finish) begin
          bus_req_d = 1'b0;
          if (req_to) begin
            err_timeout_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: begin
        bus_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // An illegal pulse only raises the flag. Its payload is dropped because
    // the transition logic above never acts on a pulse in these states.
    if (status_ready && state_q != IDLE) begin
      err_proto_d = 1'b1;
    end
    if (data_ready && state_q != WR_WAIT) begin
      err_proto_d = 1'b1;
    end
    if (rdata_read && state_q != RD_HOLD) begin
      err_proto_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      burst_q       <= 1'b0;
      rdata_q       <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      burst_q       <= burst_d;
      rdata_q       <= rdata_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
    end
  end

  assign rdata       = rdata_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_timeout_q;
  assign err_proto   = err_proto_q;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Self-checking bench for spi_bus_ctrl. A cycle table covers single reads
// and protocol errors. Hand-written sequences cover burst write, timeout,
// address wrap, abort during a request, and reset during a request.
module tb_spi_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n_o;
  logic        status_ready;
  logic        data_ready;
  logic        rdata_read;
  logic [19:0] addr;
  logic [3:0]  status;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [19:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        busy;
  logic        err_timeout;
  logic        err_proto;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_bus_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n_o       (cs_n_o),
    .status_ready (status_ready),
    .data_ready   (data_ready),
    .rdata_read   (rdata_read),
    .addr         (addr),
    .status       (status),
    .wdata        (wdata),
    .rdata        (rdata),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .err_proto    (err_proto)
  );

  typedef struct {
    logic        sr, dr, rr, ack;
    logic [19:0] addr;
    logic [3:0]  status;
    logic [15:0] wdata;
    logic [15:0] brdata;
    logic        e_req, e_we;
    logic [19:0] e_baddr;
    logic [15:0] e_bwdata;
    logic [15:0] e_rdata;
    logic        e_busy, e_et, e_ep;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_pulses();
    status_ready = 1'b0;
    data_ready   = 1'b0;
    rdata_read   = 1'b0;
    bus_ack      = 1'b0;
  endtask

  task automatic pulse_status(input logic [19:0] a, input logic [3:0] s);
    addr = a; status = s; status_ready = 1'b1;
    @(negedge clk);
    status_ready = 1'b0;
  endtask

  task automatic pulse_data(input logic [15:0] d);
    wdata = d; data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic pulse_rread();
    rdata_read = 1'b1;
    @(negedge clk);
    rdata_read = 1'b0;
  endtask

  task automatic give_ack(input logic [15:0] d);
    bus_rdata = d; bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, bus_req}, 32'd1);
  endtask

  initial begin
    int cnt;

    // Field order: sr dr rr ack addr status wdata brdata |
    //              req we baddr bwdata rdata busy et ep
    vecs[0]  = '{1,0,0,0, 20'h00010, 4'b0000, 16'h0, 16'h0,    0,0, 20'h00000, 16'h0, 16'h0000, 1,0,0};
    vecs[1]  = '{0,0,0,0, 20'h0,     4'b0000, 16'h0, 16'h0,    1,0, 20'h00010, 16'h0, 16'h0000, 1,0,0};
    vecs[2]  = '{0,0,0,0, 20'h0,     4'b0000, 16'h0, 16'h0,    1,0, 20'h00010, 16'h0, 16'h0000, 1,0,0};
    vecs[3]  = '{0,0,0,0, 20'h0,     4'b0000, 16'h0, 16'h0,    1,0, 20'h00010, 16'h0, 16'h0000, 1,0,0};
    vecs[4]  = '{0,0,0,1, 20'h0,     4'b0000, 16'h0, 16'h1234, 0,0, 20'h00010, 16'h0, 16'h1234, 1,0,0};
    vecs[5]  = '{0,1,0,0, 20'h0,     4'b0000, 16'hBEEF, 16'h0, 0,0, 20'h00010, 16'h0, 16'h1234, 1,0,1};
    vecs[6]  = '{0,0,1,0, 20'h0,     4'b0000, 16'h0, 16'h0,    0,0, 20'h00010, 16'h0, 16'h1234, 0,0,1};
    vecs[7]  = '{1,0,0,0, 20'h00020, 4'b0000, 16'h0, 16'h0,    0,0, 20'h00010, 16'h0, 16'h1234, 1,0,0};
    vecs[8]  = '{0,1,0,0, 20'h0,     4'b0000, 16'h5555, 16'h0, 1,0, 20'h00020, 16'h0, 16'h1234, 1,0,1};
    vecs[9]  = '{0,0,0,1, 20'h0,     4'b0000, 16'h0, 16'h0BCD, 0,0, 20'h00020, 16'h0, 16'h0BCD, 1,0,1};
    vecs[10] = '{0,0,1,0, 20'h0,     4'b0000, 16'h0, 16'h0,    0,0, 20'h00020, 16'h0, 16'h0BCD, 0,0,1};
    vecs[11] = '{1,0,0,0, 20'h00030, 4'b1001, 16'h0, 16'h0,    0,0, 20'h00020, 16'h0, 16'h0BCD, 1,0,0};
    vecs[12] = '{0,0,0,0, 20'h0,     4'b0000, 16'h0, 16'h0,    1,0, 20'h00030, 16'h0, 16'h0BCD, 1,0,0};
    vecs[13] = '{0,0,0,1, 20'h0,     4'b0000, 16'h0, 16'h4321, 0,0, 20'h00030, 16'h0, 16'h4321, 1,0,0};
    vecs[14] = '{0,0,1,0, 20'h0,     4'b0000, 16'h0, 16'h0,    0,0, 20'h00030, 16'h0, 16'h4321, 0,0,0};

    reset = 1'b1; cs_n_o = 1'b0;
    addr = '0; status = '0; wdata = '0; bus_rdata = '0;
    clear_pulses();
    repeat (3) @(negedge clk);
    check("rst bus_req", {31'd0, bus_req}, 32'd0);
    check("rst busy",    {31'd0, busy},    32'd0);
    check("rst rdata",   {16'd0, rdata},   32'd0);
    check("rst bus_addr", {12'd0, bus_addr}, 32'd0);
    check("rst errs",    {30'd0, err_timeout, err_proto}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Cycle table: single reads and protocol errors.
    for (int i = 0; i < NV; i++) begin
      status_ready = vecs[i].sr;
      data_ready   = vecs[i].dr;
      rdata_read   = vecs[i].rr;
      bus_ack      = vecs[i].ack;
      addr         = vecs[i].addr;
      status       = vecs[i].status;
      wdata        = vecs[i].wdata;
      bus_rdata    = vecs[i].brdata;
      @(negedge clk);
      check($sformatf("v%0d bus_req", i),   {31'd0, bus_req},   {31'd0, vecs[i].e_req});
      check($sformatf("v%0d bus_we", i),    {31'd0, bus_we},    {31'd0, vecs[i].e_we});
      check($sformatf("v%0d bus_addr", i),  {12'd0, bus_addr},  {12'd0, vecs[i].e_baddr});
      check($sformatf("v%0d bus_wdata", i), {16'd0, bus_wdata}, {16'd0, vecs[i].e_bwdata});
      check($sformatf("v%0d rdata", i),     {16'd0, rdata},     {16'd0, vecs[i].e_rdata});
      check($sformatf("v%0d busy", i),      {31'd0, busy},      {31'd0, vecs[i].e_busy});
      check($sformatf("v%0d err_timeout", i), {31'd0, err_timeout}, {31'd0, vecs[i].e_et});
      check($sformatf("v%0d err_proto", i), {31'd0, err_proto}, {31'd0, vecs[i].e_ep});
    end
    clear_pulses();
    addr = '0; status = '0; wdata = '0; bus_rdata = '0;
    @(negedge clk);

    // Burst write of three beats, then the frame ends.
    pulse_status(20'h00100, 4'b0110);
    for (int k = 0; k < 3; k++) begin
      pulse_data(16'hA001 + 16'(k));
      wait_req($sformatf("bw%0d req", k));
      check($sformatf("bw%0d we", k),    {31'd0, bus_we},    32'd1);
      check($sformatf("bw%0d addr", k),  {12'd0, bus_addr},  32'h100 + 32'(k));
      check($sformatf("bw%0d wdata", k), {16'd0, bus_wdata}, 32'hA001 + 32'(k));
      repeat (2) @(negedge clk);
      check($sformatf("bw%0d held", k),  {12'd0, bus_addr},  32'h100 + 32'(k));
      give_ack(16'h0);
      check($sformatf("bw%0d drop", k),  {31'd0, bus_req},   32'd0);
    end
    cs_n_o = 1'b1;
    @(negedge clk);
    check("bw end busy", {31'd0, busy}, 32'd0);
    cs_n_o = 1'b0;
    @(negedge clk);

    // Read timeout: bus_ack never comes.
    pulse_status(20'h00040, 4'b0000);
    wait_req("to req");
    cnt = 0;
    while (bus_req && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("to req cycles", cnt, 32'd64);
    check("to err_timeout", {31'd0, err_timeout}, 32'd1);
    check("to rdata", {16'd0, rdata}, 32'hDEAD);
    check("to busy", {31'd0, busy}, 32'd1);
    pulse_rread();
    check("to idle", {31'd0, busy}, 32'd0);
    pulse_status(20'h00041, 4'b0000);
    check("to err cleared", {31'd0, err_timeout}, 32'd0);
    wait_req("to2 req");
    give_ack(16'h1111);
    check("to2 rdata", {16'd0, rdata}, 32'h1111);
    pulse_rread();

    // Burst read wraps at the top of the address space.
    pulse_status(20'hFFFFF, 4'b0010);
    wait_req("wr0 req");
    check("wr0 addr", {12'd0, bus_addr}, 32'hFFFFF);
    give_ack(16'hAAAA);
    check("wr0 rdata", {16'd0, rdata}, 32'hAAAA);
    pulse_rread();
    wait_req("wr1 req");
    check("wr1 addr", {12'd0, bus_addr}, 32'h00000);
    give_ack(16'hBBBB);
    check("wr1 rdata", {16'd0, rdata}, 32'hBBBB);
    cs_n_o = 1'b1;
    @(negedge clk);
    check("wr end busy", {31'd0, busy}, 32'd0);
    cs_n_o = 1'b0;
    @(negedge clk);

    // Frame ends while a write waits for its ack.
    pulse_status(20'h00200, 4'b0100);
    pulse_data(16'h7777);
    wait_req("ab req");
    cs_n_o = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("ab hold%0d", k), {31'd0, bus_req}, 32'd1);
    end
    check("ab busy", {31'd0, busy}, 32'd1);
    check("ab addr", {12'd0, bus_addr}, 32'h200);
    give_ack(16'h0);
    check("ab drop", {31'd0, bus_req}, 32'd0);
    check("ab idle", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("ab no req%0d", k), {31'd0, bus_req}, 32'd0);
    end
    check("ab no err", {31'd0, err_timeout}, 32'd0);
    cs_n_o = 1'b0;
    @(negedge clk);

    // Reset lands while a read is outstanding.
    pulse_status(20'h00300, 4'b0000);
    wait_req("rs req");
    reset = 1'b1;
    @(negedge clk);
    check("rs bus_req", {31'd0, bus_req}, 32'd0);
    check("rs busy",    {31'd0, busy},    32'd0);
    check("rs rdata",   {16'd0, rdata},   32'd0);
    check("rs bus_addr", {12'd0, bus_addr}, 32'd0);
    check("rs bus_wdata", {16'd0, bus_wdata}, 32'd0);
    check("rs bus_we",  {31'd0, bus_we},  32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
